uart_frame_rx: RTL and testbench

- Frame-level receiver directly downstream of uart_byte_rx.
- Consumes the received byte (data_byte) and its one-cycle rx_done strobe.
- Parses fixed-length frames: header HEAD0, HEAD1; then DATA_BYTES payload bytes; then an 8-bit additive checksum.
- Outputs the assembled payload word with a valid pulse; flags checksum errors and inter-byte timeouts.

---
 rtl/uart_frame_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Frame-level receiver that sits behind a byte-level UART receiver. It
//   parses fixed-length frames laid out as HEAD0, HEAD1, DATA_BYTES payload
//   bytes, then an 8-bit additive checksum. A good frame is published on
//   frame_data with a one-cycle frame_valid pulse. A bad checksum or a
//   stalled frame is discarded and reported with a one-cycle error pulse.
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   reset_n      synchronous, active-low reset
//   rx_data      received byte; only looked at while rx_done is high
//   rx_done      byte strobe; every high cycle counts as one byte
//   frame_data   payload of the last good frame (first byte in the MSBs)
//   frame_valid  one-cycle pulse: frame_data was just updated
//   chk_err      one-cycle pulse: checksum mismatch, frame dropped
//   timeout_err  one-cycle pulse: inter-byte timeout, frame dropped
//   busy         high while the parser is anywhere other than IDLE
//
// Handshake: rx_done/rx_data form a valid-only stream with no back-pressure.
//   Every cycle in which rx_done is high delivers exactly one byte, and that
//   byte is consumed on the same clock edge. The outputs are registered
//   pulses, and no acknowledge is expected for them.

module uart_frame_rx #(
  parameter logic [7:0] HEAD0          = 8'h55,
  parameter logic [7:0] HEAD1          = 8'hA5,
  parameter int         DATA_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [8*DATA_BYTES-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    chk_err,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int W    = 8 * DATA_BYTES;
  localparam int BC_W = $clog2(DATA_BYTES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t          state_q,       state_d;
  logic [BC_W-1:0] byte_cnt_q,    byte_cnt_d;
  logic [7:0]      acc_q,         acc_d;
  logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
  logic [W-1:0]    shift_q,       shift_d;
  logic [W-1:0]    frame_q,       frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic            chk_err_q,     chk_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_q,        busy_d;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    acc_d         = acc_q;
    to_cnt_d      = to_cnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (rx_done) begin
      // A byte always wins over a timeout that would expire on this edge.
      to_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rx_data == HEAD0) state_d = HEAD;
        end
        HEAD: begin
          if (rx_data == HEAD1) begin
            state_d    = DATA;
            byte_cnt_d = '0;
            acc_d      = '0;
          end else if (rx_data != HEAD0) begin
            // A repeated HEAD0 keeps us waiting for HEAD1; anything else resyncs.
            state_d = IDLE;
          end
        end
        DATA: begin
          // Each new byte is shifted in at the bottom, so the first payload
          // byte ends up in the MSBs once all DATA_BYTES bytes have arrived.
          shift_d = (shift_q << 8) | W'(rx_data);
          acc_d   = acc_q + rx_data;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = CHK;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        CHK: begin
          if (rx_data == acc_q) begin
            frame_d       = shift_q;
            frame_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // The counter holds the number of idle edges since the last byte, so
      // TIMEOUT_CYCLES quiet edges in a row abandon the frame.
      if (to_cnt_q == TO_LAST) begin
        timeout_err_d = 1'b1;
        state_d       = IDLE;
        to_cnt_d      = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      acc_q         <= '0;
      to_cnt_q      <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      acc_q         <= acc_d;
      to_cnt_q      <= to_cnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = frame_valid_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx. It drives bytes directly on rx_data/rx_done.
// Expected frame events are queued as the stimulus is driven. A monitor on
// the falling edge pops them when the DUT pulses an output.

module tb_uart_frame_rx;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int W  = 8 * DB;

  localparam logic [1:0] KV = 2'd0;  // frame_valid
  localparam logic [1:0] KC = 2'd1;  // chk_err
  localparam logic [1:0] KT = 2'd2;  // timeout_err

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_done = 1'b0;
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         chk_err;
  logic         timeout_err;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] mdl_frame = '0;
  logic [W+1:0] obs_ev;
  logic [W+1:0] exp_ev;
  bit           mon_en = 1'b0;

  uart_frame_rx #(
    .HEAD0(8'h55),
    .HEAD1(8'hA5),
    .DATA_BYTES(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .chk_err(chk_err),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] ev(input logic [1:0] k, input logic [W-1:0] d);
    return {k, d};
  endfunction

  function automatic logic [7:0] csum(input logic [W-1:0] p);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < DB; i++) s = s + p[8*i +: 8];
    return s;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; the byte is sampled gap+1 edges later.
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [W-1:0] p, input int gmax, input bit corrupt);
    logic [7:0] c;
    c = csum(p);
    if (corrupt) begin
      c = c ^ 8'($urandom_range(1, 255));
      exp_q.push_back(ev(KC, '0));
    end else begin
      exp_q.push_back(ev(KV, p));
    end
    send_byte(8'h55, $urandom_range(0, gmax));
    send_byte(8'hA5, $urandom_range(0, gmax));
    for (int i = DB - 1; i >= 0; i--) send_byte(p[8*i +: 8], $urandom_range(0, gmax));
    send_byte(c, $urandom_range(0, gmax));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    if (!reset_n) begin
      mdl_frame = '0;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_valid || chk_err || timeout_err) begin
        check("single_pulse_kind", 64'($countones({frame_valid, chk_err, timeout_err})), 64'd1);
        obs_ev = frame_valid ? ev(KV, frame_data) : (chk_err ? ev(KC, '0) : ev(KT, '0));
        check("event_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_ev = exp_q.pop_front();
          check("event_match", 64'(obs_ev), 64'(exp_ev));
          if (exp_ev[W+1:W] == KV) mdl_frame = exp_ev[W-1:0];
        end
      end
      check("frame_data_stable", 64'(frame_data), 64'(mdl_frame));
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int seen;
    logic [W-1:0] p;
    logic [7:0]   nb;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_frame_data", 64'(frame_data), 64'd0);
    check("reset_frame_valid", 64'(frame_valid), 64'd0);
    check("reset_chk_err", 64'(chk_err), 64'd0);
    check("reset_timeout_err", 64'(timeout_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: good frame
    send_byte(8'h55);
    check("t1_busy_after_head0", 64'(busy), 64'd1);
    send_byte(8'hA5);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_q.push_back(ev(KV, 32'h11223344));
    send_byte(8'hAA);
    check("t1_valid_latency", 64'(frame_valid), 64'd1);
    check("t1_frame_data", 64'(frame_data), 64'h11223344);
    check("t1_chk_err", 64'(chk_err), 64'd0);
    check("t1_busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", 64'(frame_valid), 64'd0);

    // 2: bad checksum
    send_byte(8'h55); send_byte(8'hA5);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_q.push_back(ev(KC, '0));
    send_byte(8'hAB);
    check("t2_chk_err", 64'(chk_err), 64'd1);
    check("t2_no_valid", 64'(frame_valid), 64'd0);
    check("t2_frame_kept", 64'(frame_data), 64'h11223344);
    @(posedge clk); #1;
    check("t2_chk_err_one_cycle", 64'(chk_err), 64'd0);

    // 3: repeated HEAD0, then a header that breaks off
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    exp_q.push_back(ev(KV, 32'h01020304));
    send_byte(8'h0A);
    check("t3_valid", 64'(frame_valid), 64'd1);
    check("t3_frame_data", 64'(frame_data), 64'h01020304);
    send_byte(8'h55);
    check("t3_busy_head", 64'(busy), 64'd1);
    send_byte(8'h00);
    check("t3_busy_back_idle", 64'(busy), 64'd0);
    repeat (4) @(posedge clk); #1;
    check("t3_no_events", 64'(exp_q.size()), 64'd0);

    // header values inside the payload are plain data (55+A5+55+A5 = F4)
    send_byte(8'h55); send_byte(8'hA5);
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h55); send_byte(8'hA5);
    exp_q.push_back(ev(KV, 32'h55A555A5));
    send_byte(8'hF4);
    check("t3_hdr_in_payload", 64'(frame_data), 64'h55A555A5);

    // 4: timeout after TO quiet cycles
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    exp_q.push_back(ev(KT, '0));
    seen = 0;
    for (int i = 1; i <= TO + 10; i++) begin
      @(posedge clk); #1;
      if (timeout_err) begin
        seen = i;
        break;
      end
    end
    check("t4_timeout_latency", 64'(seen), 64'(TO));
    check("t4_busy_after_timeout", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t4_timeout_one_cycle", 64'(timeout_err), 64'd0);
    // longest legal gap (TO-1 idle cycles) between every byte: no timeout
    exp_q.push_back(ev(KV, 32'h10203040));
    send_byte(8'h55, TO - 1); send_byte(8'hA5, TO - 1);
    send_byte(8'h10, TO - 1); send_byte(8'h20, TO - 1);
    send_byte(8'h30, TO - 1); send_byte(8'h40, TO - 1);
    send_byte(8'hA0, TO - 1);
    check("t4_max_gap_valid", 64'(frame_valid), 64'd1);
    check("t4_max_gap_no_timeout", 64'(timeout_err), 64'd0);
    send_frame(32'hCAFE0123, 0, 1'b0);
    check("t4_next_frame", 64'(frame_data), 64'hCAFE0123);

    // 5: reset in the middle of a frame
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("t5_frame_data_cleared", 64'(frame_data), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_pulses", 64'({frame_valid, chk_err, timeout_err}), 64'd0);
    send_byte(8'h55); send_byte(8'hA5);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    exp_q.push_back(ev(KV, 32'hDEADBEEF));
    send_byte(8'h38);
    check("t5_frame_data", 64'(frame_data), 64'hDEADBEEF);

    // 6: bytes paced like a serial link (A1+B2+C3+D4 = EA); 4A is a bad sum
    exp_q.push_back(ev(KV, 32'hA1B2C3D4));
    send_byte(8'h55, 40); send_byte(8'hA5, 40);
    send_byte(8'hA1, 40); send_byte(8'hB2, 40); send_byte(8'hC3, 40); send_byte(8'hD4, 40);
    send_byte(8'hEA, 40);
    check("t6_frame_data", 64'(frame_data), 64'hA1B2C3D4);
    check("t6_no_timeout", 64'(timeout_err), 64'd0);
    exp_q.push_back(ev(KC, '0));
    send_byte(8'h55, 40); send_byte(8'hA5, 40);
    send_byte(8'hA1, 40); send_byte(8'hB2, 40); send_byte(8'hC3, 40); send_byte(8'hD4, 40);
    send_byte(8'h4A, 40);
    check("t6_bad_sum_err", 64'(chk_err), 64'd1);

    // random frames, back-to-back or with noise between, some corrupted
    for (int f = 0; f < 24; f++) begin
      p = W'($urandom());
      send_frame(p, (f % 3 == 0) ? 0 : TO - 1, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'h55) nb = 8'h00;
        send_byte(nb, $urandom_range(0, 200));
      end
    end

    repeat (5) @(posedge clk); #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
